// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data memory) in front of one
// single-port, fixed-latency memory; round-robin on contention, one access at a time.
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,

    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_stall,

    output logic          err,

    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t        r_state;
    state_t        w_next;

    logic          r_last_dm;
    logic          r_owner_dm;
    logic          r_wr;
    logic          r_err_pend;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;

    logic          w_grant_any;
    logic          w_grant_dm;
    logic [AW-1:0] w_grant_addr;
    logic          w_grant_unal;

    // On contention the requester that was not served last wins (last=fetch after reset).
    always_comb begin
        w_grant_any  = if_req | dm_req;
        w_grant_dm   = dm_req & (~if_req | ~r_last_dm);
        w_grant_addr = w_grant_dm ? dm_addr : if_addr;
        w_grant_unal = w_grant_addr[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_next = w_grant_unal ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if_done     = 1'b0;
        dm_done     = 1'b0;
        err         = 1'b0;
        case (r_state)
            S_ACCESS: begin
                mem_en      = 1'b1;
                mem_wr      = r_wr;
                mem_addr    = r_addr;
                mem_data_in = r_wdata;
            end
            S_DONE: begin
                if_done = ~r_owner_dm;
                dm_done = r_owner_dm;
                err     = r_err_pend;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_dm  <= 1'b0;
            r_owner_dm <= 1'b0;
            r_wr       <= 1'b0;
            r_err_pend <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_owner_dm <= w_grant_dm;
                        r_last_dm  <= w_grant_dm;
                        r_wr       <= w_grant_dm & dm_wr;
                        r_addr     <= w_grant_addr;
                        r_wdata    <= w_grant_dm ? dm_wdata : '0;
                        r_err_pend <= w_grant_unal;
                        r_cnt      <= w_grant_unal ? 4'd0 : LAT_M1;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (r_owner_dm) begin
                            r_dm_rdata <= r_wr ? '0 : mem_data_out;
                        end else begin
                            r_if_rdata <= mem_data_out;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model predicts grant order, done timing,
// memory activity and read data from arithmetic on grant offsets and a shadow memory.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_done;
    logic [15:0] dm_rdata;
    logic        dm_stall;
    logic        err;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] mem    [0:255];
    logic [15:0] shadow [0:255];
    int          en_run = 0;

    bit          m_last_dm;
    logic [15:0] m_if_rdata;
    logic [15:0] m_dm_rdata;

    mem_arbiter #(.MEM_LAT(LAT), .AW(16), .DW(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_done      (if_done),
        .if_rdata     (if_rdata),
        .if_stall     (if_stall),
        .dm_req       (dm_req),
        .dm_wr        (dm_wr),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_done      (dm_done),
        .dm_rdata     (dm_rdata),
        .dm_stall     (dm_stall),
        .err          (err),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-latency memory: data is only correct in the LAT-th consecutive enabled cycle.
    always @(posedge clk) begin
        if (mem_en) en_run <= en_run + 1;
        else        en_run <= 0;
        if (mem_en && mem_wr) mem[mem_addr[7:0]] = mem_data_in;
    end
    assign mem_data_out = (mem_en && en_run == LAT - 1) ? mem[mem_addr[7:0]]
                                                        : ~mem[mem_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [15:0] a);
        return a[0] ? 0 : LAT;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mem_en"}, mem_en, 1'b0);
        chk({tag, "_mem_wr"}, mem_wr, 1'b0);
        chk({tag, "_if_done"}, if_done, 1'b0);
        chk({tag, "_dm_done"}, dm_done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    // One transaction round starting from IDLE: requests sampled at the next edge (offset 0).
    task automatic run_round(input bit do_if, input logic [15:0] ia,
                             input bit do_dm, input bit dwr,
                             input logic [15:0] da, input logic [15:0] dwd);
        int gi, gd, di, dd, last;
        bit en_if, en_dm;
        logic [15:0] exp_if, exp_dm;
        gi = -1; gd = -1; di = -1; dd = -1;
        exp_if = m_if_rdata;
        exp_dm = m_dm_rdata;
        if (do_if && do_dm) begin
            if (m_last_dm) begin
                gi = 0;      di = gi + lat_of(ia);
                gd = di + 2; dd = gd + lat_of(da);
            end else begin
                gd = 0;      dd = gd + lat_of(da);
                gi = dd + 2; di = gi + lat_of(ia);
            end
        end else if (do_if) begin
            gi = 0; di = lat_of(ia);
            m_last_dm = 1'b0;
        end else if (do_dm) begin
            gd = 0; dd = lat_of(da);
            m_last_dm = 1'b1;
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (do_if && ((pass == 0) == (gi == 0)) && !ia[0])
                exp_if = shadow[ia[7:0]];
            if (do_dm && ((pass == 0) == (gd == 0)) && !da[0]) begin
                if (dwr) begin
                    exp_dm = 16'h0000;
                    shadow[da[7:0]] = dwd;
                end else begin
                    exp_dm = shadow[da[7:0]];
                end
            end
        end
        last = (di > dd) ? di : dd;

        if_req = do_if; if_addr = ia;
        dm_req = do_dm; dm_wr = dwr; dm_addr = da; dm_wdata = dwd;

        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            en_if = do_if && !ia[0] && k >= gi && k < gi + LAT;
            en_dm = do_dm && !da[0] && k >= gd && k < gd + LAT;
            chk("mem_en", mem_en, en_if | en_dm);
            chk("mem_wr", mem_wr, en_dm && dwr);
            if (en_if) chk("mem_addr_if", mem_addr, ia);
            if (en_dm) chk("mem_addr_dm", mem_addr, da);
            if (en_dm && dwr) chk("mem_data_in", mem_data_in, dwd);
            chk("if_done", if_done, do_if && k == di);
            chk("dm_done", dm_done, do_dm && k == dd);
            chk("err", err, (do_if && k == di && ia[0]) || (do_dm && k == dd && da[0]));
            chk("if_stall", if_stall, if_req && !(do_if && k == di));
            chk("dm_stall", dm_stall, dm_req && !(do_dm && k == dd));
            if (do_if && k == di) begin
                chk("if_rdata", if_rdata, exp_if);
                m_if_rdata = exp_if;
                if_req = 1'b0;
            end
            if (do_dm && k == dd) begin
                chk("dm_rdata", dm_rdata, exp_dm);
                m_dm_rdata = exp_dm;
                dm_req = 1'b0;
            end
        end
        @(posedge clk); #1;
        check_idle_outputs("post");
        chk("if_rdata_hold", if_rdata, m_if_rdata);
        chk("dm_rdata_hold", dm_rdata, m_dm_rdata);
    endtask

    initial begin
        logic [15:0] v, ia, da;
        bit          bi, bd, bw;

        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            mem[i] = v;
            shadow[i] = v;
        end
        mem[8'h10] = 16'hBEEF;
        shadow[8'h10] = 16'hBEEF;
        m_last_dm = 1'b0;
        m_if_rdata = '0;
        m_dm_rdata = '0;

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010; dm_wdata = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check_idle_outputs("reset");
            chk("reset_mem_addr", mem_addr, 16'h0000);
            chk("reset_mem_data_in", mem_data_in, 16'h0000);
            chk("reset_if_rdata", if_rdata, 16'h0000);
            chk("reset_dm_rdata", dm_rdata, 16'h0000);
        end
        rst = 1'b0;

        run_round(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("single_read_beef", dm_rdata, 16'hBEEF);

        run_round(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234);
        chk("write_rdata_zero", dm_rdata, 16'h0000);
        run_round(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("fetch_after_write", if_rdata, 16'h1234);

        for (int r = 0; r < 4; r++)
            run_round(1'b1, 16'(2 * r), 1'b1, r[0], 16'(8 + 2 * r), 16'(16'hA500 + r));

        v = m_dm_rdata;
        run_round(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0011, 16'h0000);
        chk("unaligned_rdata_kept", dm_rdata, v);

        // Reset during the second (final) ACCESS cycle of a read.
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0030;
        @(posedge clk); #1;
        chk("rstmid_access1", mem_en, 1'b1);
        @(posedge clk); #1;
        chk("rstmid_access2", mem_en, 1'b1);
        rst = 1'b1; dm_req = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("rstmid");
        chk("rstmid_dm_rdata", dm_rdata, 16'h0000);
        rst = 1'b0;
        m_last_dm = 1'b0; m_if_rdata = '0; m_dm_rdata = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_idle_outputs("rstmid_idle");
        end
        run_round(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000);

        for (int r = 0; r < 60; r++) begin
            bi = 1'($urandom);
            bd = 1'($urandom);
            if (!bi && !bd) bd = 1'b1;
            bw = 1'($urandom);
            ia = 16'($urandom_range(0, 63));
            da = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) ia[0] = 1'b0;
            if ($urandom_range(0, 3) != 0) da[0] = 1'b0;
            run_round(bi, ia, bd, bw, da, 16'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk); #1;
                check_idle_outputs("gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
